// File: rtl/lsu_riscv.sv
// lsu_riscv: load/store unit between the RISC-V decoder and a req/gnt/rvalid
// data-memory bus.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   core_req_i/we_i/size_i/addr_i/wd_i  access request from the decoder/ALU
//   core_rd_o                         extended load data (held until next load)
//   core_stall_req_o                  hold PC/instruction while the access runs
//   core_err_o                        one-cycle pulse: misaligned, illegal size, timeout
//   data_*                            data-memory bus (req/gnt, rvalid response)
// Latency: load min 3 stall cycles (data valid in DONE), store min 2.
module lsu_riscv #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_req_o,
  output logic        core_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic        err_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;

  logic        req_ok;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic        timeout_hit;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  // Decode of the incoming request: legality, byte enables, lane replication.
  always_comb begin
    req_ok    = 1'b0;
    be_new    = 4'b0000;
    wdata_new = core_wd_i;
    case (core_size_i)
      LDST_B, LDST_BU: begin
        req_ok    = 1'b1;
        be_new    = 4'b0001 << core_addr_i[1:0];
        wdata_new = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        req_ok    = ~core_addr_i[0];
        be_new    = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{core_wd_i[15:0]}};
      end
      LDST_W: begin
        req_ok    = (core_addr_i[1:0] == 2'b00);
        be_new    = 4'b1111;
        wdata_new = core_wd_i;
      end
      default: req_ok = 1'b0;
    endcase
  end

  // Counter value TIMEOUT-1 marks the last cycle allowed in REQ/RESP.
  assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

  // Load extraction: bring the addressed byte/halfword down to bit 0.
  always_comb begin
    rd_shift = data_rdata_i >> {off_q, 3'b000};
    case (size_q)
      LDST_B:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      LDST_BU: rd_ext = {24'h0, rd_shift[7:0]};
      LDST_H:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      LDST_HU: rd_ext = {16'h0, rd_shift[15:0]};
      default: rd_ext = data_rdata_i;
    endcase
  end

  // Next state and combinational outputs.
  always_comb begin
    state_d          = state_q;
    data_req_o       = 1'b0;
    core_err_o       = 1'b0;
    core_stall_req_o = core_req_i & (state_q != DONE);
    case (state_q)
      IDLE: begin
        if (core_req_i) state_d = req_ok ? REQ : DONE;
      end
      REQ: begin
        data_req_o = 1'b1;
        // A grant in the final allowed cycle still wins over the abort.
        if (data_gnt_i)       state_d = data_we_o ? DONE : RESP;
        else if (timeout_hit) state_d = DONE;
      end
      RESP: begin
        if (data_rvalid_i || timeout_hit) state_d = DONE;
      end
      DONE: begin
        core_err_o = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 16'h0;
      err_q        <= 1'b0;
      size_q       <= 3'd0;
      off_q        <= 2'd0;
      core_rd_o    <= 32'h0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'h0;
      data_addr_o  <= 32'h0;
      data_wdata_o <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (core_req_i) begin
            if (req_ok) begin
              err_q        <= 1'b0;
              cnt_q        <= 16'h0;
              size_q       <= core_size_i;
              off_q        <= core_addr_i[1:0];
              data_we_o    <= core_we_i;
              data_be_o    <= be_new;
              data_addr_o  <= {core_addr_i[31:2], 2'b00};
              data_wdata_o <= wdata_new;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            cnt_q <= 16'h0;  // fresh budget for the response phase
          end else begin
            cnt_q <= cnt_q + 16'd1;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        RESP: begin
          if (data_rvalid_i) begin
            core_rd_o <= rd_ext;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_riscv.sv
module tb_lsu_riscv;

  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        core_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic [31:0] data_rdata_i;
  logic        data_rvalid_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd = 32'h0;

  always #5 clk = ~clk;

  lsu_riscv #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_req_o(core_stall_req_o), .core_err_o(core_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rdata_i(data_rdata_i), .data_rvalid_i(data_rvalid_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access rules expressed arithmetically ----
  function automatic int m_bytes(input logic [2:0] sz);
    return 1 << sz[1:0];
  endfunction

  function automatic logic m_legal(input logic [2:0] sz, input logic [31:0] a);
    if (!(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (a % m_bytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
    int n;
    n = m_bytes(sz);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] wd);
    case (m_bytes(sz))
      1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a,
                                         input logic [31:0] r);
    longint unsigned v;
    longint unsigned span;
    int n;
    n    = m_bytes(sz);
    span = 64'd1 << (8 * n);
    v    = (longint'(r) >> (8 * (a % 4))) % span;
    if (!sz[2] && n < 4 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  // One access from the IDLE cycle through DONE, with a bus responder that
  // grants after gdly waiting REQ cycles and responds rdly cycles into RESP.
  task automatic access(input string tag, input logic [2:0] sz, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gdly, input int rdly, input logic [31:0] rdata);
    logic legal, exp_err, granted, done, err_early, bus_bad, req_seen;
    logic [31:0] exp_rd;
    int exp_stall, stall_cnt, req_cycles, since;
    legal = m_legal(sz, addr);
    exp_err = 1'b0;
    if (!legal) begin exp_err = 1'b1; exp_stall = 1; end
    else if (gdly >= TO) begin exp_err = 1'b1; exp_stall = 1 + TO; end
    else if (we) exp_stall = gdly + 2;
    else if (rdly >= TO) begin exp_err = 1'b1; exp_stall = gdly + 2 + TO; end
    else exp_stall = gdly + rdly + 3;
    exp_rd = (legal && !we && !exp_err) ? m_load(sz, addr, rdata) : model_rd;
    granted = 0; done = 0; err_early = 0; bus_bad = 0; req_seen = 0;
    stall_cnt = 0; req_cycles = 0; since = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      core_req_i = 1'b1; core_we_i = we; core_size_i = sz;
      core_addr_i = addr; core_wd_i = wd;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = $urandom;
      if (data_req_o && !granted) begin
        if (req_cycles == gdly) begin data_gnt_i = 1'b1; granted = 1'b1; end
        else data_rvalid_i = 1'($urandom_range(0, 1));
        req_cycles++;
      end else if (granted && !we) begin
        since++;
        if (since == rdly + 1) begin data_rvalid_i = 1'b1; data_rdata_i = rdata; end
      end else if (!granted) begin
        data_gnt_i = 1'($urandom_range(0, 1));
      end
      #1;
      if (core_stall_req_o) begin
        stall_cnt++;
        if (core_err_o) err_early = 1'b1;
        if (data_req_o) begin
          req_seen = 1'b1;
          if (data_addr_o !== {addr[31:2], 2'b00} || data_be_o !== m_be(sz, addr) ||
              data_we_o !== we || (we && data_wdata_o !== m_wdata(sz, wd)))
            bus_bad = 1'b1;
        end
      end else begin
        done = 1'b1;
        chk({tag, "_err"}, core_err_o, exp_err);
        chk({tag, "_rd"}, core_rd_o, exp_rd);
        chk({tag, "_stall"}, stall_cnt, exp_stall);
        chk({tag, "_done_req"}, data_req_o, 1'b0);
      end
    end
    chk({tag, "_bound"}, done, 1'b1);
    chk({tag, "_err_early"}, err_early, 1'b0);
    chk({tag, "_bus"}, bus_bad, 1'b0);
    chk({tag, "_req_seen"}, req_seen, legal);
    model_rd = exp_rd;
  endtask

  // Idle cycles with stray gnt/rvalid that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      core_req_i = 1'b0;
      data_gnt_i = 1'($urandom_range(0, 1));
      data_rvalid_i = 1'($urandom_range(0, 1));
      data_rdata_i = $urandom;
      #1;
      chk("idle_stall", core_stall_req_o, 1'b0);
      chk("idle_req", data_req_o, 1'b0);
      chk("idle_err", core_err_o, 1'b0);
      chk("idle_rd", core_rd_o, model_rd);
    end
  endtask

  initial begin
    rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'h0; core_wd_i = 32'h0; data_gnt_i = 1'b0;
    data_rdata_i = 32'h0; data_rvalid_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", core_rd_o, 32'h0);
    chk("rst_err", core_err_o, 1'b0);
    chk("rst_req", data_req_o, 1'b0);
    chk("rst_we", data_we_o, 1'b0);
    chk("rst_be", data_be_o, 4'h0);
    chk("rst_addr", data_addr_o, 32'h0);
    chk("rst_wdata", data_wdata_o, 32'h0);
    @(negedge clk); rst_i = 1'b0;
    idle(1);

    // Directed cases
    access("lb", 3'd0, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_FF7F);
    chk("lb_value", model_rd, 32'hFFFF_FF80);
    idle(1);
    access("lhu", 3'd5, 1'b0, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234);
    chk("lhu_value", model_rd, 32'h0000_8001);
    access("lh", 3'd1, 1'b0, 32'h0000_2002, 32'h0, 1, 0, 32'h8001_1234);
    chk("lh_value", model_rd, 32'hFFFF_8001);
    idle(1);
    access("sb", 3'd0, 1'b1, 32'h0000_3001, 32'hDEAD_BEEF, 4, 0, 32'h0);
    access("lw_mis", 3'd2, 1'b0, 32'h0000_4002, 32'h0, 0, 0, 32'h0);
    access("sz3", 3'd3, 1'b0, 32'h0000_4000, 32'h0, 0, 0, 32'h0);
    idle(1);
    access("to_resp", 3'd2, 1'b0, 32'h0000_4000, 32'h0, 0, 1000, 32'h0);
    idle(3);
    access("to_req", 3'd2, 1'b1, 32'h0000_4000, 32'h1, TO, 0, 32'h0);
    idle(1);

    // Reset while waiting in RESP; the late rvalid must be ignored.
    access("pre_rst", 3'd2, 1'b0, 32'h0000_6000, 32'h0, 0, 0, 32'hCAFE_F00D);
    idle(1);
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h6004;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    @(negedge clk); data_gnt_i = 1'b1;
    @(negedge clk); data_gnt_i = 1'b0; rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0; core_req_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    #1;
    chk("rst_mid_req", data_req_o, 1'b0);
    chk("rst_mid_rd", core_rd_o, 32'h0);
    chk("rst_mid_addr", data_addr_o, 32'h0);
    chk("rst_mid_be", data_be_o, 4'h0);
    model_rd = 32'h0;
    idle(2);

    // Back-to-back with core_req_i held across DONE
    access("b2b_sw", 3'd2, 1'b1, 32'h0000_5000, 32'h0BAD_F00D, 0, 0, 32'h0);
    access("b2b_lw", 3'd2, 1'b0, 32'h0000_5000, 32'h0, 0, 0, 32'h0BAD_F00D);
    idle(1);

    // Randomized accesses
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = $urandom;
      access("rnd", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
